// File: rtl/note_sprite_plotter.sv
// note_sprite_plotter
//
// Moves a fixed-size note sprite vertically inside one lane of a 160x120
// VGA frame. Each accepted row sample first erases the sprite at the row it
// was last drawn at, then draws it at the new (clamped) row. One pixel write
// is issued per cycle, and every output is registered.
//
// Ports:
//   clk        - single clock for all logic
//   resetn     - asynchronous, active-low reset
//   y_valid    - one-cycle strobe qualifying y_in
//   y_in       - requested sprite top row (clamped to 120-H)
//   vga_x      - pixel column
//   vga_y      - pixel row
//   vga_colour - pixel colour
//   vga_plot   - pixel write enable
//   busy       - high while a move is in progress or a sample is pending
module note_sprite_plotter #(
  parameter int         X_POS     = 76,
  parameter int         W         = 4,
  parameter int         H         = 4,
  parameter logic [2:0] COLOUR    = 3'b110,
  parameter logic [2:0] BG_COLOUR = 3'b000
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       y_valid,
  input  logic [7:0] y_in,
  output logic [7:0] vga_x,
  output logic [6:0] vga_y,
  output logic [2:0] vga_colour,
  output logic       vga_plot,
  output logic       busy
);

  typedef enum logic [1:0] {IDLE, ERASE, DRAW} state_t;

  localparam logic [7:0] Y_MAX   = 8'(120 - H);
  localparam logic [2:0] PX_LAST = 3'(W - 1);
  localparam logic [2:0] PY_LAST = 3'(H - 1);
  localparam logic [7:0] X_BASE  = 8'(X_POS);

  state_t     state_q, state_d;
  logic [2:0] px_q, px_d, py_q, py_d;
  logic [6:0] prev_y_q, prev_y_d;
  logic       has_prev_q, has_prev_d;
  logic       pend_valid_q, pend_valid_d;
  logic [6:0] pend_y_q, pend_y_d;
  logic [6:0] cur_y_q, cur_y_d;
  logic [7:0] vga_x_q, vga_x_d;
  logic [6:0] vga_y_q, vga_y_d;
  logic [2:0] vga_colour_q, vga_colour_d;
  logic       vga_plot_q, vga_plot_d;
  logic       busy_q, busy_d;

  logic [6:0] y_clamp;
  logic [6:0] sample;
  logic       last_col;
  logic [2:0] px_next, py_next;
  logic [6:0] base_row;

  assign y_clamp = (y_in > Y_MAX) ? Y_MAX[6:0] : y_in[6:0];

  // Next-state logic. The registered pixel outputs are computed from the
  // pixel about to be scanned, so the first pixel of a move appears in the
  // cycle right after the accepting edge and ERASE hands over to DRAW with
  // no idle gap.
  always_comb begin
    state_d      = state_q;
    px_d         = px_q;
    py_d         = py_q;
    prev_y_d     = prev_y_q;
    has_prev_d   = has_prev_q;
    pend_valid_d = pend_valid_q;
    pend_y_d     = pend_y_q;
    cur_y_d      = cur_y_q;
    vga_x_d      = vga_x_q;
    vga_y_d      = vga_y_q;
    vga_colour_d = vga_colour_q;
    vga_plot_d   = 1'b0;
    sample       = y_valid ? y_clamp : pend_y_q;
    last_col     = (px_q == PX_LAST);
    px_next      = last_col ? 3'd0 : px_q + 3'd1;
    py_next      = last_col ? py_q + 3'd1 : py_q;
    base_row     = (state_q == ERASE) ? prev_y_q : cur_y_q;

    // Strobes arriving mid-move are parked; only the newest survives.
    if (y_valid && state_q != IDLE) begin
      pend_valid_d = 1'b1;
      pend_y_d     = y_clamp;
    end

    case (state_q)
      IDLE: begin
        if (y_valid || pend_valid_q) begin
          pend_valid_d = 1'b0;
          cur_y_d      = sample;
          px_d         = 3'd0;
          py_d         = 3'd0;
          if (!has_prev_q) begin
            state_d      = DRAW;
            vga_x_d      = X_BASE;
            vga_y_d      = sample;
            vga_colour_d = COLOUR;
            vga_plot_d   = 1'b1;
          end else if (sample != prev_y_q) begin
            state_d      = ERASE;
            vga_x_d      = X_BASE;
            vga_y_d      = prev_y_q;
            vga_colour_d = BG_COLOUR;
            vga_plot_d   = 1'b1;
          end
        end
      end
      ERASE, DRAW: begin
        if (last_col && py_q == PY_LAST) begin
          px_d = 3'd0;
          py_d = 3'd0;
          if (state_q == ERASE) begin
            state_d      = DRAW;
            vga_x_d      = X_BASE;
            vga_y_d      = cur_y_q;
            vga_colour_d = COLOUR;
            vga_plot_d   = 1'b1;
          end else begin
            state_d    = IDLE;
            prev_y_d   = cur_y_q;
            has_prev_d = 1'b1;
          end
        end else begin
          px_d         = px_next;
          py_d         = py_next;
          vga_x_d      = X_BASE + 8'(px_next);
          vga_y_d      = base_row + 7'(py_next);
          vga_colour_d = (state_q == ERASE) ? BG_COLOUR : COLOUR;
          vga_plot_d   = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE) | pend_valid_d;
  end

  // State and output registers. Reset returns everything to zero but leaves
  // the screen untouched, so the next sample draws without an erase.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= IDLE;
      px_q         <= 3'd0;
      py_q         <= 3'd0;
      prev_y_q     <= 7'd0;
      has_prev_q   <= 1'b0;
      pend_valid_q <= 1'b0;
      pend_y_q     <= 7'd0;
      cur_y_q      <= 7'd0;
      vga_x_q      <= 8'd0;
      vga_y_q      <= 7'd0;
      vga_colour_q <= 3'd0;
      vga_plot_q   <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      px_q         <= px_d;
      py_q         <= py_d;
      prev_y_q     <= prev_y_d;
      has_prev_q   <= has_prev_d;
      pend_valid_q <= pend_valid_d;
      pend_y_q     <= pend_y_d;
      cur_y_q      <= cur_y_d;
      vga_x_q      <= vga_x_d;
      vga_y_q      <= vga_y_d;
      vga_colour_q <= vga_colour_d;
      vga_plot_q   <= vga_plot_d;
      busy_q       <= busy_d;
    end
  end

  assign vga_x      = vga_x_q;
  assign vga_y      = vga_y_q;
  assign vga_colour = vga_colour_q;
  assign vga_plot   = vga_plot_q;
  assign busy       = busy_q;

endmodule

// File: doc/note_sprite_plotter.md
# note_sprite_plotter

Downstream consumer of the double-buffered note-position byte stream. Each accepted 8-bit position sample moves a fixed-size note sprite vertically within one screen lane. On a new sample the block erases the sprite at its previous row, then draws it at the new row. It emits one pixel write per cycle to the 160x120 VGA adapter (x, y, colour, plot).

## Interface
Parameters:
- X_POS, 76: left column of the sprite lane. X_POS+W-1 must be ≤ 159.
- W, 4: sprite width in pixels, 1..8.
- H, 4: sprite height in pixels, 1..8.
- COLOUR, 3'b110: sprite colour.
- BG_COLOUR, 3'b000: erase colour.

Ports:
- clk, in, 1: single clock for all logic.
- resetn, in, 1: reset, asynchronous and active-low.
- y_valid, in, 1: one-cycle strobe; the y_in sample is valid this cycle.
- y_in, in, 8: requested sprite top row.
- vga_x, out, 8: pixel column.
- vga_y, out, 7: pixel row.
- vga_colour, out, 3: pixel colour.
- vga_plot, out, 1: pixel write enable.
- busy, out, 1: high while a move is in progress or pending.

## Operation
- Clamping: an accepted row is yc = min(y_in, 120-H), 7 bits.
- State is held in the following registers:
  - state: IDLE, ERASE, DRAW.
  - px, py: pixel counters.
  - prev_y (7b) and has_prev: last drawn row.
  - pend_valid and pend_y: one-deep pending sample.
  - cur_y: target row of the current move.
- IDLE:
  - If y_valid or pend_valid is set, take the sample; y_valid has priority over pend_valid and clears it.
  - If has_prev=1 and yc == prev_y, drop the sample: no plot, stay in IDLE.
  - If has_prev=0, go to DRAW.
  - Otherwise go to ERASE.
  - In every case load cur_y=yc and px=py=0.
- ERASE: one pixel per cycle. vga_x=X_POS+px, vga_y=prev_y+py, colour BG_COLOUR, plot=1.
- DRAW: one pixel per cycle. vga_x=X_POS+px, vga_y=cur_y+py, colour COLOUR, plot=1.
- Scan order (ERASE and DRAW): raster order, px fastest. After px=W-1 wrap px to 0 and increment py. At px=W-1 and py=H-1, ERASE goes to DRAW and DRAW goes to IDLE.
- End of DRAW: prev_y←cur_y and has_prev←1.
- y_valid while not IDLE: store the clamped row in pend_y and set pend_valid. A newer strobe overwrites an older pending value; only the newest is kept.
- busy = (state != IDLE) | pend_valid, registered.
- Arithmetic: X_POS+px and row+py are computed unsigned and never exceed 159 and 119 given the clamp and parameter limits. No wrap-around handling is required.
- Reset, whether asynchronous or mid-operation:
  - state=IDLE, px=py=0, has_prev=0, pend_valid=0, prev_y=cur_y=pend_y=0.
  - All outputs 0: vga_x=0, vga_y=0, vga_colour=0, vga_plot=0, busy=0.
  - Screen contents are not cleared.

## Timing
- All outputs are registered.
- y_valid sampled at edge n: vga_plot is high from cycle n+1.
- First move after reset: W*H contiguous plot cycles (n+1..n+W*H).
- Later moves: 2*W*H contiguous plot cycles (n+1..n+2*W*H), with no gap between ERASE and DRAW.
- busy rises at n+1 and falls in the cycle after the last plot, unless pend_valid is set.
- Pending start: one IDLE cycle with plot=0 separates the end of one DRAW from the first plot of the next move.
- Dropped sample (equal row): vga_plot stays 0 and busy stays 0.
- When vga_plot=0, vga_x, vga_y and vga_colour hold their last values.

## Test plan
With defaults W=H=4, X_POS=76:
- Reset → all outputs 0. Pulse resetn low mid-DRAW → next cycle plot=0 and busy=0; the next sample draws with no erase.
- First sample y_in=10 → 16 plot cycles starting cycle n+1, colour 110. First pixel (76,10), last pixel (79,13). No BG pixels.
- Then y_in=20 → 16 BG pixels over rows 10..13, then 16 pixels at colour 110 over rows 20..23. All 32 plot cycles contiguous; busy drops in the cycle after.
- y_in=200 → clamped to 116: draw rows 116..119, no row above 119.
- Repeat y_in=20 after it is drawn → zero plot cycles, busy stays 0.
- While busy, strobe 30 then 40 → the current move completes, one idle cycle follows, then erase at the old row and draw at rows 40..43. Row 30 is never drawn.
